// File: rtl/rv_word_pkg.sv
// Shared types for the RV toggle-port word server: FSM states, latched command, strobe bits.
package rv_word_pkg;

   typedef enum logic [2:0] {
      S_CLEAR,
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_RESP
   } rv_word_state_t;

   localparam int DS_HI = 1;   // strobe for [15:8]
   localparam int DS_LO = 0;   // strobe for [7:0]

   typedef struct packed {
      logic [15:0] din;
      logic [1:0]  ds;
      logic        we;
      logic        tgt;        // ack level to return on completion
   } rv_word_cmd_t;

endpackage

// File: rtl/rv_word_bram.sv
// Single-port 16-bit RAM with per-byte write enables and registered read data.
module rv_word_bram
   import rv_word_pkg::*;
#(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [1:0]            be,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [15:0]           wdata,
   output logic [15:0]           rdata
);

   logic [15:0] mem [0:(1<<ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            if (be[DS_HI]) mem[addr][15:8] <= wdata[15:8];
            if (be[DS_LO]) mem[addr][7:0]  <= wdata[7:0];
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/rv_word_server.sv
// Toggle req/ack word responder backed by block RAM, with slot delay and post-reset zero fill.
module rv_word_server
   import rv_word_pkg::*;
#(
   parameter int ADDR_WIDTH     = 16,
   parameter int WAIT_CYCLES    = 3,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  resetn,
   output logic                  busy,
   input  logic [ADDR_WIDTH-1:0] rv_addr,
   input  logic [15:0]           rv_din,
   input  logic [1:0]            rv_ds,
   input  logic                  rv_we,
   input  logic                  rv_req,
   output logic                  rv_req_ack,
   output logic [15:0]           rv_dout
);

   localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam rv_word_state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

   rv_word_state_t        state, state_nxt;
   rv_word_cmd_t          cmd;
   logic [ADDR_WIDTH-1:0] cmd_addr, clr_cnt;
   logic [WCW-1:0]        wait_cnt;
   logic                  pending, clr_last;

   logic                  ram_en, ram_we;
   logic [1:0]            ram_be;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [15:0]           ram_wdata, ram_rdata;

   assign pending  = (rv_req != rv_req_ack);
   assign clr_last = &clr_cnt;
   assign busy     = (state == S_CLEAR);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= RST_STATE;
      else         state <= state_nxt;
   end

   // The RAM port is shared between the zero fill and the single ACCESS cycle.
   always_comb begin
      state_nxt = state;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_be    = 2'b00;
      ram_addr  = cmd_addr;
      ram_wdata = cmd.din;
      case (state)
         S_CLEAR: begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_be    = 2'b11;
            ram_addr  = clr_cnt;
            ram_wdata = 16'h0000;
            if (clr_last) state_nxt = S_IDLE;
         end
         S_IDLE:   if (pending) state_nxt = S_WAIT;
         S_WAIT:   if (wait_cnt == '0) state_nxt = S_ACCESS;
         S_ACCESS: begin
            ram_en    = 1'b1;
            ram_we    = cmd.we;
            ram_be    = cmd.ds;
            state_nxt = S_RESP;
         end
         S_RESP:   state_nxt = S_IDLE;
         default:  state_nxt = RST_STATE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         clr_cnt    <= '0;
         wait_cnt   <= '0;
         cmd        <= '0;
         cmd_addr   <= '0;
         rv_req_ack <= 1'b0;
         rv_dout    <= 16'h0000;
      end else begin
         case (state)
            // Hold at the last address so the counter can never re-enter the fill.
            S_CLEAR: if (!clr_last) clr_cnt <= clr_cnt + 1'b1;
            S_IDLE: begin
               if (pending) begin
                  cmd_addr <= rv_addr;
                  cmd      <= '{din: rv_din, ds: rv_ds, we: rv_we, tgt: rv_req};
                  wait_cnt <= WCW'(WAIT_CYCLES);
               end
            end
            S_WAIT: if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
            S_RESP: begin
               if (!cmd.we) rv_dout <= ram_rdata;
               rv_req_ack <= cmd.tgt;
            end
            default: ;
         endcase
      end
   end

   rv_word_bram #(.ADDR_WIDTH(ADDR_WIDTH)) u_bram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .be    (ram_be),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

endmodule

// File: doc/rv_word_server.md
# rv_word_server

Responder end of the 16-bit toggle request/acknowledge word port the iosys RV bridge uses to reach memory (rv_req/rv_req_ack, rv_ds byte strobes, rv_we). It accepts one word access per toggle, services it from an on-chip block RAM after a programmable slot delay, and returns data together with the ack toggle. It is the drop-in target for that bridge in simulation and BRAM-backed builds, replacing the SDRAM controller's RV slot, and it clears its memory after reset while holding `busy`.

## Interface
- `ADDR_WIDTH`, 16: word-address width; memory depth is 2^ADDR_WIDTH × 16 bits.
- `WAIT_CYCLES`, 3: extra idle cycles inserted before each access (models SDRAM slot latency); 0 is legal.
- `CLEAR_ON_RESET`, 1: 1 zero-fills the RAM after reset; 0 skips the fill.
- `clk` in 1: single clock; all logic is on its rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `busy` out 1: high while the post-reset clear runs.
- `rv_addr` in ADDR_WIDTH: word address.
- `rv_din` in 16: write data.
- `rv_ds` in 2: byte strobes; bit1 = [15:8], bit0 = [7:0]. Ignored for reads.
- `rv_we` in 1: 1 = write, 0 = read.
- `rv_req` in 1: request toggle. `rv_req != rv_req_ack` means a request is pending.
- `rv_req_ack` out 1: acknowledge toggle. Set equal to `rv_req` when the access completes.
- `rv_dout` out 16: read data; valid when `rv_req == rv_req_ack` after a read.

## Operation
- States: CLEAR, IDLE, WAIT, ACCESS, RESP.
- Reset values:
  - `rv_req_ack` = 0, `rv_dout` = 0.
  - State = CLEAR with `busy` = 1 if `CLEAR_ON_RESET`; otherwise IDLE with `busy` = 0.
  - Clear counter = 0, wait counter = 0.
- CLEAR:
  - One word written to 0 per cycle, at addresses 0 … 2^ADDR_WIDTH−1.
  - After the last word: `busy` ← 0, go to IDLE.
  - A toggle arriving during CLEAR stays pending and is served afterwards.
- IDLE: when `rv_req != rv_req_ack`:
  - Latch `rv_addr`, `rv_din`, `rv_ds`, `rv_we`, and the target ack value (= `rv_req`).
  - Load the wait counter with `WAIT_CYCLES`; go to WAIT.
- WAIT: if counter = 0, go to ACCESS; else decrement.
- ACCESS: one RAM cycle with the latched command.
  - Write: update only bytes whose `ds` bit is 1. `ds` = 00 is a no-op write that is still acknowledged.
  - Read: synchronous read, data available next cycle.
  - Next state: RESP.
- RESP:
  - For reads, `rv_dout` ← RAM output; for writes, `rv_dout` is unchanged.
  - `rv_req_ack` ← latched target, then go to IDLE.
- Inputs are sampled only in IDLE. Changes to `rv_req` or the address/data inputs while a request is in flight are ignored.
  - A second toggle before ack is a protocol violation. The responder completes the first request; on return to IDLE it sees mismatch or equality as the level dictates.
- Requesters must reset `rv_req` to 0 with the same `resetn`. Otherwise a mismatch immediately after reset counts as a pending request.
- Asserting `resetn` mid-operation aborts the access, may leave a partially cleared RAM, and restarts CLEAR.

## Timing
- Request sampled on edge E0 (IDLE→WAIT).
- Ack toggles and `rv_dout` updates together on edge E0 + WAIT_CYCLES + 3.
- Reads: the requester may capture `rv_dout` on the first edge at which it sees `rv_req == rv_req_ack`. Data holds until the next read completes.
- Back-to-back: the next request can be sampled on the edge after RESP. Throughput is one word per WAIT_CYCLES + 4 cycles.
- A 32-bit RV read is two requests, so 2 × (WAIT_CYCLES + 4) cycles of responder time.
- Clear takes 2^ADDR_WIDTH cycles after reset release; `busy` falls on the edge that writes the final address.
- Addresses are exactly ADDR_WIDTH bits, so there is no out-of-range case. The clear counter must not wrap back into CLEAR.

## Structure
- `rv_word_pkg`:
  - state enum `rv_word_state_t` (CLEAR, IDLE, WAIT, ACCESS, RESP);
  - localparams for the byte-strobe bit positions.
- Sub-module `rv_word_bram`:
  - single-port, 16-bit, 2-bit byte-enable, synchronous-read RAM;
  - inferred, no reset on its contents.
- The wait counter is sized $clog2(WAIT_CYCLES+1), minimum 1 bit.

## Test plan
- Reset with `CLEAR_ON_RESET`=1, ADDR_WIDTH=4 → `busy` high for 16 cycles; a read of every address returns 0x0000.
- Write 0xBEEF at 0x3, ds=11, then toggle a read at 0x3 → `rv_dout`=0xBEEF; ack lags each toggle by exactly WAIT_CYCLES+3 edges (6 at default).
- Write 0x1234 at 0x5; write 0xAB00 ds=10; write 0x00CD ds=01; write 0xFFFF ds=00 → read returns 0xABCD.
- Toggle `rv_req` during CLEAR → no ack until `busy` falls, then the request is served correctly.
- 100 random back-to-back reads/writes with WAIT_CYCLES=0 → matches the reference model; gap between acks = 4 cycles.
- Assert `resetn` during WAIT of a write → `rv_req_ack`=0 and `busy`=1 immediately; after clear the target word reads 0.
